// File: rtl/nios_sys_gpio_pkg.sv
// Shared register map and edge-capture mode encodings for the Nios GPIO peripheral.
package nios_sys_gpio_pkg;

   localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
   localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
   localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_sys_gpio_edge.sv
// Two-flop input synchroniser plus a delayed copy for per-bit edge detection.
module nios_sys_gpio_edge
   import nios_sys_gpio_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int EDGE_TYPE = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] det
);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= in_port;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;
   assign sync = sync2_q;

   generate
      if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign det = fall;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
         assign det = rise | fall;
      end else begin : g_rise
         assign det = rise;
      end
   endgenerate

endmodule

// File: rtl/nios_sys_gpio.sv
// Avalon-MM GPIO slave: output register with set/clear, synchronised input,
// edge capture and a maskable level interrupt. Zero-wait, read latency 0.
module nios_sys_gpio
   import nios_sys_gpio_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int          EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] det;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] clear;
   logic             wr_en;
   logic             unused_wdata;

   nios_sys_gpio_edge #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .sync    (sync_in),
      .det     (det)
   );

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;

   always_comb begin
      data_out_d = data_out_q;
      irq_mask_d = irq_mask_q;
      clear      = '0;
      if (wr_en) begin
         case (address)
            ADDR_DATA_OUT: data_out_d = wdata;
            ADDR_IRQ_MASK: irq_mask_d = wdata;
            ADDR_EDGE_CAP: clear      = wdata;
            ADDR_OUT_SET:  data_out_d = data_out_q | wdata;
            ADDR_OUT_CLR:  data_out_d = data_out_q & ~wdata;
            default: ;
         endcase
      end
      // OR-ing det after the clear lets a coincident edge win over W1C
      edge_cap_d = (edge_cap_q & ~clear) | det;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RESET_VALUE[WIDTH-1:0];
         irq_mask_q <= '0;
         edge_cap_q <= '0;
      end else begin
         data_out_q <= data_out_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
      end
   end

   always_comb begin
      readdata = 32'h0;
      case (address)
         ADDR_DATA_OUT: readdata = 32'(data_out_q);
         ADDR_DATA_IN:  readdata = 32'(sync_in);
         ADDR_IRQ_MASK: readdata = 32'(irq_mask_q);
         ADDR_EDGE_CAP: readdata = 32'(edge_cap_q);
         default:       readdata = 32'h0;
      endcase
   end

   assign out_port = data_out_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
